// File: rtl/mpmod_addsub_pkg.sv
// Shared constants and FSM encoding for the modular add/subtract controller.
package mpmod_addsub_pkg;

  localparam int MPMOD_WIDTH = 1027;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OP1_ISSUE = 3'd1,
    ST_OP1_WAIT  = 3'd2,
    ST_OP2_ISSUE = 3'd3,
    ST_OP2_WAIT  = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/mpmod_addsub.sv
// Modular add/subtract controller. It computes (a+b) mod m or (a-b) mod m
// by driving two operations on an external mpadder. Two operations are
// always issued, so the latency does not depend on the data.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start, subtract        request pulse and mode (sampled only in IDLE)
//   in_a, in_b, in_m       operands and modulus (sampled with start)
//   result, done, busy     modular result, completion pulse, busy flag
//   add_start, add_subtract, add_in_a, add_in_b   requests to the adder
//   add_result, add_done                           answers from the adder
//
// state      | meaning
// IDLE       | waiting for start
// OP1_ISSUE  | add_start for a+b or a-b
// OP1_WAIT   | waiting for the first add_done
// OP2_ISSUE  | add_start for r1-m (add) or r1+m (sub)
// OP2_WAIT   | waiting for the second add_done; result registered here
// DONE       | done=1 for one cycle
module mpmod_addsub
  import mpmod_addsub_pkg::*;
#(
  parameter int WIDTH = MPMOD_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r1_q;
  logic             sub_q;
  logic             borrow1_q;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_OP1_ISSUE;
      ST_OP1_ISSUE: state_nxt = ST_OP1_WAIT;
      ST_OP1_WAIT:  if (add_done) state_nxt = ST_OP2_ISSUE;
      ST_OP2_ISSUE: state_nxt = ST_OP2_WAIT;
      ST_OP2_WAIT:  if (add_done) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign add_start = (state == ST_OP1_ISSUE) || (state == ST_OP2_ISSUE);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Adder operands are loaded one cycle before each ISSUE state and left
  // untouched until the matching add_done, so they are stable throughout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_q          <= '0;
      r1_q         <= '0;
      sub_q        <= 1'b0;
      borrow1_q    <= 1'b0;
      result       <= '0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_q          <= in_m;
            sub_q        <= subtract;
            add_in_a     <= in_a;
            add_in_b     <= in_b;
            add_subtract <= subtract;
          end
        end
        ST_OP1_WAIT: begin
          if (add_done) begin
            r1_q         <= add_result[WIDTH-1:0];
            borrow1_q    <= add_result[WIDTH];
            add_in_a     <= add_result[WIDTH-1:0];
            add_in_b     <= m_q;
            add_subtract <= ~sub_q;
          end
        end
        ST_OP2_WAIT: begin
          if (add_done) begin
            // add: keep r1 when r1-m borrowed; sub: fold back when a-b borrowed
            if (sub_q) result <= borrow1_q ? add_result[WIDTH-1:0] : r1_q;
            else       result <= add_result[WIDTH] ? r1_q : add_result[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpmod_addsub.sv
module tb_mpmod_addsub;
  import mpmod_addsub_pkg::*;

  localparam int W = MPMOD_WIDTH;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         subtract = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic [W-1:0] result;
  logic         done, busy, add_start, add_subtract;
  logic [W-1:0] add_in_a, add_in_b;
  logic [W:0]   add_result = '0;
  logic         add_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  mpmod_addsub #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done),
    .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result),
    .add_done(add_done)
  );

  always #5 clk = ~clk;

  // mpadder model: add_done arrives 2 cycles after the add_start cycle.
  logic       pend = 1'b0;
  logic [W:0] pend_res = '0;
  bit         overlap_seen = 1'b0;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (pend) begin
      add_done   <= 1'b1;
      add_result <= pend_res;
      pend       <= 1'b0;
    end
    if (add_start) begin
      if (pend || add_done) overlap_seen <= 1'b1;
      pend     <= 1'b1;
      pend_res <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                               : ({1'b0, add_in_a} + {1'b0, add_in_b});
    end
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int           done_cyc, n_done, n_st;
  int           st_cyc[2];
  logic         st_sub[2];
  logic [W-1:0] res_at_done, res_end;
  logic [15:0]  busy_hist;

  // Caller is at a negedge; start is driven immediately (cycle 0).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic sub, input bit inject);
    in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
    done_cyc = -1; n_done = 0; n_st = 0; busy_hist = '0;
    st_cyc[0] = -1; st_cyc[1] = -1; st_sub[0] = 1'bx; st_sub[1] = 1'bx;
    res_at_done = 'x;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && (c == 2 || c == 5)) begin
        start = 1'b1; in_a = 5; in_b = 1; in_m = 11; subtract = ~sub;
      end
      busy_hist[c] = busy;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = c; res_at_done = result; end
      end
      if (add_start) begin
        if (n_st < 2) begin st_cyc[n_st] = c; st_sub[n_st] = add_subtract; end
        n_st++;
      end
    end
    res_end = result;
    @(negedge clk);
  endtask

  logic [W-1:0] big_a, big_m, big_exp;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_result", result, 0);
    chk("rst_add_in_a", add_in_a, 0);
    @(negedge clk);
    resetn = 1'b1;

    // add with wrap, started in the first cycle after reset release
    run_op(7, 9, 13, 1'b0, 1'b0);
    chk("add_wrap_result", res_at_done, 3);
    chk("add_wrap_done_cyc", done_cyc, 7);
    chk("add_wrap_n_done", n_done, 1);
    chk("add_start_cyc0", st_cyc[0], 1);
    chk("add_start_cyc1", st_cyc[1], 4);
    chk("add_start_sub0", st_sub[0], 0);
    chk("add_start_sub1", st_sub[1], 1);
    chk("add_start_count", n_st, 2);
    chk("busy_cyc1", busy_hist[1], 1);
    chk("busy_cyc7", busy_hist[7], 1);
    chk("busy_cyc8", busy_hist[8], 0);
    chk("result_held", res_end, 3);

    run_op(3, 4, 13, 1'b0, 1'b0);
    chk("add_nowrap", res_at_done, 7);
    run_op(6, 7, 13, 1'b0, 1'b0);
    chk("add_eq_m", res_at_done, 0);

    run_op(4, 9, 13, 1'b1, 1'b0);
    chk("sub_borrow", res_at_done, 8);
    chk("sub_done_cyc", done_cyc, 7);
    run_op(9, 4, 13, 1'b1, 1'b0);
    chk("sub_noborrow", res_at_done, 5);
    run_op(11, 11, 13, 1'b1, 1'b0);
    chk("sub_equal", res_at_done, 0);

    // full width: m = 2^1025+1, a = b = 2^1025
    big_a = '0; big_a[1025] = 1'b1;
    big_m = big_a; big_m[0] = 1'b1;
    big_exp = big_a - 1;
    run_op(big_a, big_a, big_m, 1'b0, 1'b0);
    chk("full_width", res_at_done, big_exp);

    // starts during busy are ignored
    run_op(7, 9, 13, 1'b0, 1'b1);
    chk("busy_start_result", res_at_done, 3);
    chk("busy_start_n_done", n_done, 1);
    chk("busy_start_done_cyc", done_cyc, 7);
    chk("busy_start_held", res_end, 3);

    // reset during OP2_WAIT
    in_a = 7; in_b = 9; in_m = 13; subtract = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", dut.state, ST_IDLE);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_add_start", add_start, 0);
    chk("midrst_add_sub", add_subtract, 0);
    chk("midrst_add_in_a", add_in_a, 0);
    chk("midrst_add_in_b", add_in_b, 0);
    chk("midrst_result", result, 0);
    resetn = 1'b1;
    @(negedge clk);
    run_op(4, 9, 13, 1'b1, 1'b0);
    chk("post_rst_result", res_at_done, 8);
    chk("post_rst_done_cyc", done_cyc, 7);

    chk("no_overlap", overlap_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
